instr_fetch_unit: RTL and testbench

- Fetch stage sitting directly upstream of the multi-cycle CPU core's controlpath/datapath.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake with variable latency.
- Holds the fetched instruction stable for DECODE/EXECUTE and applies sequential, branch or halt PC updates driven by the core FSM.
- Flags a memory timeout as a sticky error.

---
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC ownership, imem req/ack with timeout, instruction hold
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1),
    parameter int                TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic              upd_pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              halt,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] ins_out,
    output logic              ins_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic              fetch_busy,
    output logic              halted,
    output logic              fetch_err
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_HOLD   = 3'd2,
        S_HALTED = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              imem_req_q, imem_req_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0] ins_q, ins_d;
    logic              ins_valid_q, ins_valid_d;
    logic              fetch_err_q, fetch_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Next-state and registered-output logic; HALTED and ERR hold everything.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        ins_d       = ins_q;
        ins_valid_d = ins_valid_q;
        fetch_err_d = fetch_err_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_req) begin
                    state_d     = S_REQ;
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_q;
                    cnt_d       = '0;
                end
            end
            S_REQ: begin
                // An ack arriving on the timeout cycle still wins.
                if (imem_ack) begin
                    state_d     = S_HOLD;
                    ins_d       = imem_rdata;
                    ins_valid_d = 1'b1;
                    imem_req_d  = 1'b0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d     = S_ERR;
                    imem_req_d  = 1'b0;
                    fetch_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                // halt beats upd_pc so the PC of the halt instruction is kept.
                if (halt) begin
                    state_d     = S_HALTED;
                    ins_valid_d = 1'b0;
                end else if (upd_pc) begin
                    state_d     = S_IDLE;
                    ins_valid_d = 1'b0;
                    pc_d        = br_taken ? br_target : pc_q + PC_STEP;
                end
            end
            default: ;
        endcase
    end

    // State register with synchronous active-low reset taking priority.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pc_q        <= PC_RESET;
            imem_req_q  <= 1'b0;
            imem_addr_q <= PC_RESET;
            ins_q       <= '0;
            ins_valid_q <= 1'b0;
            fetch_err_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            ins_q       <= ins_d;
            ins_valid_q <= ins_valid_d;
            fetch_err_q <= fetch_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = imem_addr_q;
    assign ins_out    = ins_q;
    assign ins_valid  = ins_valid_q;
    assign pc_out     = pc_q;
    assign fetch_err  = fetch_err_q;
    assign fetch_busy = (state_q == S_REQ);
    assign halted     = (state_q == S_HALTED);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset, fetch_req, upd_pc, br_taken, halt, imem_ack;
    logic [AW-1:0] br_target;
    logic [DW-1:0] imem_rdata;
    logic          imem_req, ins_valid, fetch_busy, halted, fetch_err;
    logic [AW-1:0] imem_addr, pc_out;
    logic [DW-1:0] ins_out;

    instr_fetch_unit #(
        .ADDR_W(AW), .DATA_W(DW), .PC_RESET(32'd0), .PC_STEP(32'd1), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .upd_pc(upd_pc),
        .br_taken(br_taken), .br_target(br_target), .halt(halt),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ins_out(ins_out), .ins_valid(ins_valid),
        .pc_out(pc_out), .fetch_busy(fetch_busy), .halted(halted), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic rst, freq, upd, brt; logic [31:0] tgt; logic hlt, ack; logic [31:0] rdata;
        logic req; logic [31:0] addr, ins; logic iv; logic [31:0] pc; logic busy, hl, err;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_all(input string t, input logic req, input logic [31:0] addr,
                           input logic [31:0] ins, input logic iv, input logic [31:0] pc,
                           input logic busy, input logic hl, input logic err);
        chk({t, ".imem_req"}, imem_req, req);
        chk({t, ".imem_addr"}, imem_addr, addr);
        chk({t, ".ins_out"}, ins_out, ins);
        chk({t, ".ins_valid"}, ins_valid, iv);
        chk({t, ".pc_out"}, pc_out, pc);
        chk({t, ".fetch_busy"}, fetch_busy, busy);
        chk({t, ".halted"}, halted, hl);
        chk({t, ".fetch_err"}, fetch_err, err);
    endtask

    task automatic setin(input logic r, input logic f, input logic u, input logic b,
                         input logic [31:0] t, input logic h, input logic a, input logic [31:0] d);
        reset = r; fetch_req = f; upd_pc = u; br_taken = b;
        br_target = t; halt = h; imem_ack = a; imem_rdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic f, input logic u, input logic b,
                         input logic [31:0] t, input logic h, input logic a, input logic [31:0] d);
        setin(r, f, u, b, t, h, a, d);
        tick();
    endtask

    // Behavioural reference: the fetch unit seen as a sequence of transactions.
    localparam int M_IDLE = 0, M_WAIT = 1, M_HAVE = 2, M_HALT = 3, M_DEAD = 4;
    int          m_mode, m_waited;
    logic [31:0] m_pc, m_addr, m_ins;
    logic        m_req, m_iv, m_err;

    task automatic model_step();
        if (!reset) begin
            m_mode = M_IDLE; m_waited = 0; m_pc = 0; m_addr = 0; m_ins = 0;
            m_req = 0; m_iv = 0; m_err = 0;
        end else if (m_mode == M_IDLE) begin
            if (fetch_req) begin
                m_mode = M_WAIT; m_req = 1; m_addr = m_pc; m_waited = 0;
            end
        end else if (m_mode == M_WAIT) begin
            if (imem_ack) begin
                m_mode = M_HAVE; m_ins = imem_rdata; m_iv = 1; m_req = 0;
            end else begin
                m_waited++;
                if (m_waited >= TO) begin
                    m_mode = M_DEAD; m_req = 0; m_err = 1;
                end
            end
        end else if (m_mode == M_HAVE) begin
            if (halt) begin
                m_mode = M_HALT; m_iv = 0;
            end else if (upd_pc) begin
                m_mode = M_IDLE; m_iv = 0;
                m_pc = br_taken ? br_target : m_pc + 32'd1;
            end
        end
    endtask

    initial begin
        setin(0, 0, 0, 0, 0, 0, 0, 0);

        // rst freq upd brt tgt hlt ack rdata | req addr ins iv pc busy hl err
        tbl.push_back('{0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,0,0});
        tbl.push_back('{1,1,0,0,0,0,0,0,                 1,0,0,0,0,1,0,0});
        tbl.push_back('{1,0,0,0,0,0,1,32'h20010005,      0,0,32'h20010005,1,0,0,0,0});
        tbl.push_back('{1,0,1,0,32'h99,0,0,0,            0,0,32'h20010005,0,1,0,0,0});
        tbl.push_back('{1,1,0,0,0,0,0,0,                 1,1,32'h20010005,0,1,1,0,0});
        tbl.push_back('{1,0,0,0,0,0,1,32'h11,            0,1,32'h11,1,1,0,0,0});
        tbl.push_back('{1,1,1,1,3,0,0,0,                 0,1,32'h11,0,3,0,0,0});
        tbl.push_back('{1,1,0,0,0,0,0,0,                 1,3,32'h11,0,3,1,0,0});
        tbl.push_back('{1,0,1,0,0,1,1,32'h22,            0,3,32'h22,1,3,0,0,0});
        tbl.push_back('{1,0,1,1,32'h40,0,0,0,            0,3,32'h22,0,32'h40,0,0,0});
        tbl.push_back('{1,1,0,0,0,0,0,0,                 1,32'h40,32'h22,0,32'h40,1,0,0});
        tbl.push_back('{1,1,0,0,0,0,1,32'h33,            0,32'h40,32'h33,1,32'h40,0,0,0});
        tbl.push_back('{1,0,1,0,0,0,0,0,                 0,32'h40,32'h33,0,32'h41,0,0,0});
        tbl.push_back('{1,0,0,0,0,0,1,32'hDEAD,          0,32'h40,32'h33,0,32'h41,0,0,0});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].freq, tbl[i].upd, tbl[i].brt, tbl[i].tgt,
                  tbl[i].hlt, tbl[i].ack, tbl[i].rdata);
            chk_all($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].ins, tbl[i].iv,
                    tbl[i].pc, tbl[i].busy, tbl[i].hl, tbl[i].err);
        end

        // Ack on the last allowed REQ cycle is accepted.
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        chk("lat.addr", imem_addr, 32'h41);
        for (int i = 0; i < TO - 1; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
        chk("lat.req_held", imem_req, 1'b1);
        chk("lat.no_err_yet", fetch_err, 1'b0);
        drive(1, 0, 0, 0, 0, 0, 1, 32'h44);
        chk("lat.ins", ins_out, 32'h44);
        chk("lat.valid", ins_valid, 1'b1);
        chk("lat.err", fetch_err, 1'b0);
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        chk("lat.pc", pc_out, 32'h42);

        // No ack: error after TIMEOUT REQ cycles.
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < TO - 1; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
        chk("to.req_before", imem_req, 1'b1);
        chk("to.err_before", fetch_err, 1'b0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        chk("to.req_after", imem_req, 1'b0);
        chk("to.err_after", fetch_err, 1'b1);
        chk("to.busy_after", fetch_busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0, 0, 1, 32'hBEEF);
            chk("err.req", imem_req, 1'b0);
            chk("err.sticky", fetch_err, 1'b1);
            chk("err.ins", ins_out, 32'h44);
        end

        // Halt wins over upd_pc.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst.err", fetch_err, 1'b0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 32'h55);
        drive(1, 0, 1, 1, 32'h99, 1, 0, 0);
        chk("halt.halted", halted, 1'b1);
        chk("halt.pc", pc_out, 32'h0);
        chk("halt.valid", ins_valid, 1'b0);
        chk("halt.ins", ins_out, 32'h55);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 1, 32'h77, 0, 1, 32'h1234);
            chk("halt.no_req", imem_req, 1'b0);
            chk("halt.stays", halted, 1'b1);
            chk("halt.pc_frozen", pc_out, 32'h0);
        end

        // PC wrap from all-ones.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 32'h66);
        drive(1, 0, 1, 1, 32'hFFFFFFFF, 0, 0, 0);
        chk("wrap.br_pc", pc_out, 32'hFFFFFFFF);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        chk("wrap.addr", imem_addr, 32'hFFFFFFFF);
        drive(1, 0, 0, 0, 0, 0, 1, 32'h77);
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        chk("wrap.pc", pc_out, 32'h0);

        // Reset mid-REQ, then a stray ack.
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        chk("rstreq.req", imem_req, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk_all("rstreq.rst", 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 32'hBAD);
        chk_all("rstreq.stray", 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized run against the reference model.
        setin(0, 0, 0, 0, 0, 0, 0, 0);
        model_step();
        tick();
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 99) != 0);
            fetch_req  = 1'($urandom_range(0, 1));
            upd_pc     = 1'($urandom_range(0, 1));
            br_taken   = 1'($urandom_range(0, 1));
            br_target  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : 32'($urandom);
            halt       = ($urandom_range(0, 15) == 0);
            imem_ack   = ($urandom_range(0, 3) == 0);
            imem_rdata = 32'($urandom);
            model_step();
            tick();
            chk_all($sformatf("rnd%0d", c), m_req, m_addr, m_ins, m_iv, m_pc,
                    (m_mode == M_WAIT), (m_mode == M_HALT), m_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
